instr_fetch_unit: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register for the pipelined MIPS core. It generates the instruction-memory request stream and captures returned words into the IF/ID register. It presents `opcode`/`func` to the control unit; an empty IF/ID slot presents opcode 0 / func 0, which the control unit decodes as NOP. It also absorbs decode-stage stalls with a one-entry skid buffer, and handles branch/jump/JR redirects, including a redirect that arrives while a memory request is outstanding.

---
 rtl/instr_fetch_unit.sv | 125 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: imem request FSM, one-entry skid buffer
// and IF/ID pipeline register, with in-flight redirect handling.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc4,
  output logic [5:0]  opcode,
  output logic [5:0]  func
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DROP  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [31:0] fetch_addr;
  logic [31:0] pend_pc;
  logic [31:0] buf_instr;
  logic [31:0] buf_pc4;
  logic [31:0] seq_addr;

  // Word increment; the low two bits ride along untouched.
  assign seq_addr  = {fetch_addr[31:2] + 30'd1, fetch_addr[1:0]};
  assign imem_addr = fetch_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  state_nx = FETCH;
      FETCH: begin
        if (imem_ready) begin
          if (!redirect_valid && stall) state_nx = HOLD;
        end else if (redirect_valid) begin
          state_nx = DROP;
        end
      end
      DROP:  if (imem_ready) state_nx = FETCH;
      HOLD:  if (redirect_valid || !stall) state_nx = FETCH;
    endcase
  end

  always_comb begin
    imem_req = (state == FETCH) || (state == DROP);
    opcode   = id_valid ? id_instr[31:26] : 6'd0;
    func     = id_valid ? id_instr[5:0]   : 6'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_addr <= RESET_PC;
      pend_pc    <= '0;
      buf_instr  <= '0;
      buf_pc4    <= '0;
      id_valid   <= 1'b0;
      id_instr   <= '0;
      id_pc4     <= '0;
    end else begin
      unique case (state)
        IDLE: ;
        FETCH: begin
          if (imem_ready) begin
            if (redirect_valid) begin
              fetch_addr <= redirect_pc;
            end else begin
              fetch_addr <= seq_addr;
              if (stall) begin
                buf_instr <= imem_rdata;
                buf_pc4   <= seq_addr;
              end else begin
                id_valid <= 1'b1;
                id_instr <= imem_rdata;
                id_pc4   <= seq_addr;
              end
            end
          end else if (redirect_valid) begin
            pend_pc <= redirect_pc;
          end else if (!stall) begin
            id_valid <= 1'b0;
          end
        end
        DROP: begin
          if (redirect_valid) pend_pc <= redirect_pc;
          if (imem_ready)
            fetch_addr <= redirect_valid ? redirect_pc : pend_pc;
          if (!stall) id_valid <= 1'b0;
        end
        HOLD: begin
          if (redirect_valid) begin
            fetch_addr <= redirect_pc;
          end else if (!stall) begin
            id_valid <= 1'b1;
            id_instr <= buf_instr;
            id_pc4   <= buf_pc4;
          end
        end
      endcase
      // A taken branch flushes IF/ID regardless of state or stall.
      if (redirect_valid) begin
        id_valid <= 1'b0;
        id_instr <= '0;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit: address-stream reference model
// feeding a scoreboard of expected IF/ID deliveries.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc4;
  logic [5:0]  opcode;
  logic [5:0]  func;

  int n_checks = 0;
  int n_pass = 0;
  int n_delivered = 0;

  logic [31:0] sb[$];
  logic [31:0] exp_fetch = '0;
  logic [31:0] doomed_addr = '0;
  bit          doomed = 1'b0;
  bit          prev_redir = 1'b0;
  int          wait_left = 0;
  int          max_wait = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk),
    .rst(rst),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ready(imem_ready),
    .imem_rdata(imem_rdata),
    .stall(stall),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .id_valid(id_valid),
    .id_instr(id_instr),
    .id_pc4(id_pc4),
    .opcode(opcode),
    .func(func)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]};
  endfunction

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, got, exp);
  endtask

  // Monitor: every word decode consumes must be the next expected one.
  always @(negedge clk) begin : mon
    logic [31:0] pc;
    logic [31:0] w;
    if (rst) begin
      sb.delete();
      prev_redir = 1'b0;
    end else begin
      if (prev_redir)
        chk("flush_bubble", 32'({id_valid, opcode, func}), 32'd0);
      if (id_valid && !stall) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_word: got pc4 %h want none", id_pc4);
        end else begin
          pc = sb.pop_front();
          w  = mem_word(pc);
          n_delivered++;
          chk("id_pc4", id_pc4, pc + 32'd4);
          chk("id_instr", id_instr, w);
          chk("opcode", 32'(opcode), 32'(w[31:26]));
          chk("func", 32'(func), 32'(w[5:0]));
        end
      end
      if (redirect_valid) sb.delete();
      prev_redir = redirect_valid;
    end
  end

  // One cycle of stimulus: memory responder plus fetch-stream model.
  task automatic step(input int p_stall, input int p_redir);
    bit         rd;
    logic [7:0] r8;
    @(posedge clk);
    #1;
    rd = int'($urandom_range(99)) < p_redir;
    r8 = 8'($urandom_range(255));
    stall = int'($urandom_range(99)) < p_stall;
    redirect_valid = rd;
    if ($urandom_range(3) == 0) redirect_pc = {26'h3FF_FFFF, r8[3:0], 2'b00};
    else                        redirect_pc = {22'h0, r8, 2'b00};
    imem_ready = 1'b0;
    imem_rdata = '0;
    if (imem_req) begin
      if (wait_left == 0) begin
        imem_ready = 1'b1;
        imem_rdata = mem_word(imem_addr);
        wait_left  = int'($urandom_range(max_wait));
      end else begin
        wait_left--;
      end
    end
    if (imem_ready) begin
      if (doomed) begin
        chk("drop_addr", imem_addr, doomed_addr);
        doomed = 1'b0;
      end else begin
        chk("fetch_addr", imem_addr, exp_fetch);
        if (!rd) sb.push_back(exp_fetch);
        exp_fetch = exp_fetch + 32'd4;
      end
    end else if (imem_req && rd && !doomed) begin
      doomed      = 1'b1;
      doomed_addr = imem_addr;
    end
    if (rd) exp_fetch = redirect_pc;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"}, 32'(imem_req), 32'd0);
    chk({tag, "_valid"}, 32'(id_valid), 32'd0);
    chk({tag, "_opfunc"}, 32'({opcode, func}), 32'd0);
    chk({tag, "_addr"}, imem_addr, 32'd0);
  endtask

  initial begin
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_req", 32'(imem_req), 32'd0);
    step(0, 0);
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, 32'd0);
    repeat (5) step(0, 0);
    step(0, 0);
    chk("zero_wait_rate", 32'(n_delivered), 32'd5);

    for (int ph = 0; ph < 8; ph++) begin
      max_wait = ph % 4;
      repeat (300) step(15 * (ph % 4) + 5, (ph < 4) ? 8 : 25);
    end

    max_wait = 1;
    for (int k = 0; k < 300 && !(id_valid && stall && !imem_req); k++)
      step(70, 0);
    chk("reach_hold", 32'({id_valid, imem_req}), 32'd2);
    #2 rst = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    imem_ready = 1'b0;
    imem_rdata = '0;
    #1 check_reset_outputs("async_rst");
    exp_fetch = '0;
    doomed = 1'b0;
    wait_left = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("restart_idle", 32'(imem_req), 32'd0);
    step(0, 0);
    chk("restart_req", 32'(imem_req), 32'd1);
    chk("restart_addr", imem_addr, 32'd0);

    max_wait = 2;
    repeat (600) step(30, 10);
    max_wait = 0;
    repeat (20) step(0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
